// File: rtl/sm_cp0_vic.sv
// sm_cp0_vic: CP0 coprocessor with a vectored interrupt controller.
//
// This block provides the Count and Compare timer, the Status, Cause and EPC
// registers, syscall/RI/overflow exceptions, and the hardware interrupt lines.
// Each line can be level-sensitive or rising-edge latched. When Cause.IV is
// set, interrupts dispatch to per-interrupt handler addresses.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   cp0_PC          address saved into EPC when a request is taken
//   cp0_EPC         current EPC register
//   cp0_ExcHandler  handler address for the current request
//   cp0_ExcAsync    interrupt request (combinational)
//   cp0_ExcSync     synchronous exception request (combinational)
//   cp0_ExcEret     ERET executed; clears Status.EXL at the next edge
//   cp0_regNum/Sel  register address for cp0_regRD / writes
//   cp0_regRD       combinational read data
//   cp0_regWD/WE    write data / write enable
//   cp0_HwIrq       asynchronous hardware interrupt lines
//   cp0_ExcRI/Sys/Ov reserved-instruction, syscall, overflow exceptions
module sm_cp0_vic #(
   parameter int          HW_IRQ_NUM  = 5,
   parameter logic [4:0]  HW_IRQ_EDGE = 5'b00000,
   parameter logic [31:0] EXC_BASE    = 32'h0000_0000,
   parameter int          VEC_SPACING = 32,
   parameter int          COUNT_DIV   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           cp0_PC,
   output logic [31:0]           cp0_EPC,
   output logic [31:0]           cp0_ExcHandler,
   output logic                  cp0_ExcAsync,
   output logic                  cp0_ExcSync,
   input  logic                  cp0_ExcEret,
   input  logic [4:0]            cp0_regNum,
   input  logic [2:0]            cp0_regSel,
   output logic [31:0]           cp0_regRD,
   input  logic [31:0]           cp0_regWD,
   input  logic                  cp0_regWE,
   input  logic [HW_IRQ_NUM-1:0] cp0_HwIrq,
   input  logic                  cp0_ExcRI,
   input  logic                  cp0_ExcSys,
   input  logic                  cp0_ExcOv
);

   localparam int PW     = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam int VEC_SH = $clog2(VEC_SPACING);
   localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

   // Architectural state
   logic [31:0]           count, compare, epc;
   logic [PW-1:0]         presc;
   logic                  cnt_tick;
   logic [7:0]            im;
   logic                  exl, ie;
   logic                  ti, dc, iv;
   logic [1:0]            ip_sw;
   logic [4:0]            exc_code;
   logic [HW_IRQ_NUM-1:0] irq_sync, irq_hist, edge_ip;

   // Derived signals
   logic [4:0]  hw_ip;
   logic [7:0]  ip, pend;
   logic        sync_src, taken, wrap;
   logic        count_we, compare_we, status_we, cause_we, epc_we;
   logic [31:0] reg_rd;

   function automatic logic [2:0] top_bit(input logic [7:0] v);
      top_bit = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) top_bit = 3'(i);
   endfunction

   function automatic logic [4:0] exc_code_of(input logic ri, input logic sys,
                                              input logic ov);
      if (ri)       exc_code_of = 5'h0a;
      else if (sys) exc_code_of = 5'h08;
      else if (ov)  exc_code_of = 5'h0c;
      else          exc_code_of = 5'h00;
   endfunction

   assign count_we   = cp0_regWE && cp0_regSel == 3'd0 && cp0_regNum == 5'd9;
   assign compare_we = cp0_regWE && cp0_regSel == 3'd0 && cp0_regNum == 5'd11;
   assign status_we  = cp0_regWE && cp0_regSel == 3'd0 && cp0_regNum == 5'd12;
   assign cause_we   = cp0_regWE && cp0_regSel == 3'd0 && cp0_regNum == 5'd13;
   assign epc_we     = cp0_regWE && cp0_regSel == 3'd0 && cp0_regNum == 5'd14;

   always_comb begin
      hw_ip = 5'b0;
      for (int k = 0; k < HW_IRQ_NUM; k++)
         hw_ip[k] = HW_IRQ_EDGE[k] ? edge_ip[k] : irq_sync[k];
   end

   assign ip   = {ti, hw_ip, ip_sw};
   assign pend = ip & im;

   assign sync_src     = cp0_ExcRI | cp0_ExcSys | cp0_ExcOv;
   assign cp0_ExcSync  = ~exl & sync_src;
   assign cp0_ExcAsync = ~exl & ie & (|pend) & ~sync_src;
   assign taken        = cp0_ExcSync | cp0_ExcAsync;

   assign cp0_ExcHandler = (cp0_ExcAsync && iv)
      ? EXC_BASE + 32'h200 + (32'(top_bit(pend)) << VEC_SH)
      : EXC_BASE + 32'h180;

   assign cp0_EPC = epc;
   assign wrap    = (presc == PRE_MAX);

   // Synchroniser and edge history for the hardware lines. A history of 0
   // out of reset makes a line held high through reset count as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_sync <= '0;
         irq_hist <= '0;
         edge_ip  <= '0;
      end else begin
         irq_sync <= cp0_HwIrq;
         irq_hist <= irq_sync;
         for (int k = 0; k < HW_IRQ_NUM; k++) begin
            if (cause_we && !cp0_regWD[10+k]) edge_ip[k] <= 1'b0;
            // A new edge beats a software clear so no edge is ever lost.
            if (irq_sync[k] && !irq_hist[k])  edge_ip[k] <= 1'b1;
         end
      end
   end

   // Count/Compare timer. cnt_tick marks a Count value reached by counting.
   // Only those values are compared against Compare, so the reset state
   // (both 0) and software Count loads do not fire the timer interrupt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         compare  <= '0;
         presc    <= '0;
         cnt_tick <= 1'b0;
         ti       <= 1'b0;
      end else begin
         if (count_we) begin
            count    <= cp0_regWD;
            presc    <= '0;
            cnt_tick <= 1'b0;
         end else begin
            presc    <= wrap ? '0 : presc + 1'b1;
            cnt_tick <= wrap & ~dc;
            if (wrap && !dc) count <= count + 32'd1;
         end
         if (compare_we) compare <= cp0_regWD;
         if (compare_we)
            ti <= 1'b0;
         else if (cnt_tick && !dc && count == compare)
            ti <= 1'b1;
      end
   end

   // Status, Cause and EPC. A taken request beats software writes to EXL and EPC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         im       <= '0;
         ie       <= 1'b0;
         exl      <= 1'b0;
         dc       <= 1'b0;
         iv       <= 1'b0;
         ip_sw    <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         if (status_we) begin
            im <= cp0_regWD[15:8];
            ie <= cp0_regWD[0];
         end
         if (taken)            exl <= 1'b1;
         else if (status_we)   exl <= cp0_regWD[1];
         else if (cp0_ExcEret) exl <= 1'b0;

         if (cause_we) begin
            dc    <= cp0_regWD[27];
            iv    <= cp0_regWD[23];
            ip_sw <= cp0_regWD[9:8];
         end
         if (taken) exc_code <= exc_code_of(cp0_ExcRI, cp0_ExcSys, cp0_ExcOv);

         if (taken)       epc <= cp0_PC;
         else if (epc_we) epc <= cp0_regWD;
      end
   end

   always_comb begin
      reg_rd = '0;
      if (cp0_regSel == 3'd0) begin
         case (cp0_regNum)
            5'd9:    reg_rd = count;
            5'd11:   reg_rd = compare;
            5'd12:   reg_rd = {16'b0, im, 6'b0, exl, ie};
            5'd13:   reg_rd = {1'b0, ti, 2'b0, dc, 3'b0, iv, 7'b0, ip, 1'b0,
                               exc_code, 2'b0};
            5'd14:   reg_rd = epc;
            default: reg_rd = '0;
         endcase
      end
   end

   assign cp0_regRD = reg_rd;

endmodule

// File: tb/tb_sm_cp0_vic.sv
// tb_sm_cp0_vic: self-checking bench for sm_cp0_vic. Line 1 is edge-latched
// and line 0 is level-sensitive. Count runs with a prescaler of 2.
module tb_sm_cp0_vic;

   localparam int DIV = 2;

   logic        clk, rst;
   logic [31:0] pc, epc_o, handler, rd_data, wd;
   logic        exc_async, exc_sync, eret, we, ri, sys, ov;
   logic [4:0]  regnum;
   logic [2:0]  regsel;
   logic [4:0]  hwirq;

   int checks = 0;
   int errors = 0;

   sm_cp0_vic #(
      .HW_IRQ_NUM(5), .HW_IRQ_EDGE(5'b00010), .EXC_BASE(32'h0000_0000),
      .VEC_SPACING(32), .COUNT_DIV(DIV)
   ) dut (
      .clk(clk), .rst(rst), .cp0_PC(pc), .cp0_EPC(epc_o),
      .cp0_ExcHandler(handler), .cp0_ExcAsync(exc_async), .cp0_ExcSync(exc_sync),
      .cp0_ExcEret(eret), .cp0_regNum(regnum), .cp0_regSel(regsel),
      .cp0_regRD(rd_data), .cp0_regWD(wd), .cp0_regWE(we), .cp0_HwIrq(hwirq),
      .cp0_ExcRI(ri), .cp0_ExcSys(sys), .cp0_ExcOv(ov)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] n, input logic [31:0] d);
      regnum = n; regsel = 3'd0; wd = d; we = 1'b1;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input logic [4:0] n, input logic [2:0] s, output logic [31:0] d);
      regnum = n; regsel = s;
      #1;
      d = rd_data;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst = 1'b1; pc = '0; eret = 0; we = 0; wd = '0; regnum = '0; regsel = '0;
      hwirq = '0; ri = 0; sys = 0; ov = 0;
      step(); step();
      rst = 1'b0;
      step(); step();
      rd(5'd9, 3'd0, r);
      checks++; if (r !== 32'd1) begin errors++; $display("FAIL count_2cyc got %h want %h", r, 32'd1); end
      repeat (8) step();
      rd(5'd9, 3'd0, r);
      checks++; if (r !== 32'd5) begin errors++; $display("FAIL count_10cyc got %h want %h", r, 32'd5); end
      for (int i = 0; i < 6; i++) begin
         logic [4:0] n;
         logic [2:0] s;
         n = (i == 0) ? 5'd11 : (i == 1) ? 5'd12 : (i == 2) ? 5'd13 :
             (i == 3) ? 5'd14 : (i == 4) ? 5'd5 : 5'd9;
         s = (i == 5) ? 3'd1 : 3'd0;
         rd(n, s, r);
         checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_reg%0d_%0d got %h want 0", n, s, r); end
      end
      checks++; if (exc_async !== 1'b0 || exc_sync !== 1'b0) begin errors++; $display("FAIL reset_req got %b%b want 00", exc_async, exc_sync); end
      checks++; if (handler !== 32'h180) begin errors++; $display("FAIL reset_handler got %h want %h", handler, 32'h180); end
      checks++; if (epc_o !== 32'd0) begin errors++; $display("FAIL reset_epc got %h want 0", epc_o); end
   endtask

   task automatic test_timer();
      logic [31:0] r;
      int n;
      wr(5'd9, 32'd0);  n = 0;
      wr(5'd11, 32'd8); n++;
      wr(5'd12, 32'h0000_8001); n++;
      while (n < 16) begin
         step(); n++;
         rd(5'd9, 3'd0, r);
         checks++; if (r !== 32'(n / DIV)) begin errors++; $display("FAIL count_run n=%0d got %h want %h", n, r, 32'(n / DIV)); end
      end
      rd(5'd13, 3'd0, r);
      checks++; if (r[30] !== 1'b0 || exc_async !== 1'b0) begin errors++; $display("FAIL ti_early got ti=%b async=%b want 0 0", r[30], exc_async); end
      step();
      rd(5'd13, 3'd0, r);
      checks++; if (r !== 32'h4000_8000) begin errors++; $display("FAIL ti_set cause got %h want %h", r, 32'h4000_8000); end
      checks++; if (exc_async !== 1'b1 || handler !== 32'h180) begin errors++; $display("FAIL timer_req got async=%b hnd=%h want 1 %h", exc_async, handler, 32'h180); end
      pc = $urandom & 32'hFFFF_FFFC;
      step();
      rd(5'd12, 3'd0, r);
      checks++; if (r !== 32'h0000_8003) begin errors++; $display("FAIL timer_exl got %h want %h", r, 32'h8003); end
      checks++; if (epc_o !== pc) begin errors++; $display("FAIL timer_epc got %h want %h", epc_o, pc); end
      checks++; if (exc_async !== 1'b0) begin errors++; $display("FAIL timer_masked got %b want 0", exc_async); end
      wr(5'd11, 32'h0000_1000);
      rd(5'd13, 3'd0, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL ti_clear cause got %h want 0", r); end
      eret = 1'b1; step(); eret = 1'b0;
      rd(5'd12, 3'd0, r);
      checks++; if (r !== 32'h0000_8001) begin errors++; $display("FAIL timer_eret got %h want %h", r, 32'h8001); end
   endtask

   task automatic test_edge_vector();
      logic [31:0] r;
      wr(5'd12, 32'h0000_0801);
      wr(5'd13, 32'h0080_0000);
      hwirq = 5'b00010; step(); hwirq = 5'b0;
      rd(5'd13, 3'd0, r);
      checks++; if (r[15:8] !== 8'h00 || exc_async !== 1'b0) begin errors++; $display("FAIL edge_early got ip=%h async=%b want 00 0", r[15:8], exc_async); end
      step();
      rd(5'd13, 3'd0, r);
      checks++; if (r[15:8] !== 8'h08) begin errors++; $display("FAIL edge_ip got %h want 08", r[15:8]); end
      checks++; if (exc_async !== 1'b1 || handler !== 32'h260) begin errors++; $display("FAIL edge_vec got async=%b hnd=%h want 1 %h", exc_async, handler, 32'h260); end
      pc = $urandom & 32'hFFFF_FFFC;
      step();
      rd(5'd12, 3'd0, r);
      checks++; if (r !== 32'h0000_0803 || epc_o !== pc) begin errors++; $display("FAIL edge_taken got st=%h epc=%h want 803 %h", r, epc_o, pc); end
      checks++; if (handler !== 32'h180) begin errors++; $display("FAIL edge_hnd_idle got %h want %h", handler, 32'h180); end
      repeat (3) step();
      wr(5'd13, 32'h0080_0800);
      rd(5'd13, 3'd0, r);
      checks++; if (r[15:8] !== 8'h08) begin errors++; $display("FAIL edge_keep got %h want 08", r[15:8]); end
      wr(5'd13, 32'h0080_0000);
      rd(5'd13, 3'd0, r);
      checks++; if (r[15:8] !== 8'h00) begin errors++; $display("FAIL edge_clear got %h want 00", r[15:8]); end
      eret = 1'b1; step(); eret = 1'b0;
      checks++; if (exc_async !== 1'b0) begin errors++; $display("FAIL edge_after got %b want 0", exc_async); end
   endtask

   task automatic test_level();
      logic [31:0] r;
      hwirq = 5'b00001; step(); step();
      rd(5'd13, 3'd0, r);
      checks++; if (r[15:8] !== 8'h04) begin errors++; $display("FAIL level_hi got %h want 04", r[15:8]); end
      hwirq = 5'b0; step(); step();
      rd(5'd13, 3'd0, r);
      checks++; if (r[15:8] !== 8'h00) begin errors++; $display("FAIL level_lo got %h want 00", r[15:8]); end
   endtask

   task automatic test_sync_priority();
      logic [31:0] r;
      wr(5'd12, 32'h0000_0101);
      wr(5'd13, 32'h0000_0100);
      #1;
      checks++; if (exc_async !== 1'b1) begin errors++; $display("FAIL sw_pend got %b want 1", exc_async); end
      ri = 1'b1; ov = 1'b1; #1;
      checks++; if (exc_sync !== 1'b1 || exc_async !== 1'b0) begin errors++; $display("FAIL sync_wins got s=%b a=%b want 1 0", exc_sync, exc_async); end
      pc = $urandom & 32'hFFFF_FFFC;
      step(); ri = 1'b0; ov = 1'b0;
      rd(5'd13, 3'd0, r);
      checks++; if (r[6:2] !== 5'h0a || epc_o !== pc) begin errors++; $display("FAIL code_ri got code=%h epc=%h want 0a %h", r[6:2], epc_o, pc); end
      sys = 1'b1; #1;
      checks++; if (exc_sync !== 1'b0) begin errors++; $display("FAIL sync_exl got %b want 0", exc_sync); end
      sys = 1'b0;
   endtask

   task automatic test_eret();
      logic [31:0] r;
      eret = 1'b1; #1;
      checks++; if (exc_async !== 1'b0) begin errors++; $display("FAIL eret_cycle got %b want 0", exc_async); end
      step(); eret = 1'b0;
      rd(5'd12, 3'd0, r);
      checks++; if (exc_async !== 1'b1 || r !== 32'h0000_0101) begin errors++; $display("FAIL eret_next got a=%b st=%h want 1 101", exc_async, r); end
   endtask

   task automatic test_random_sync();
      logic [31:0] r;
      logic [2:0]  m;
      logic [4:0]  code;
      for (int i = 0; i < 10; i++) begin
         m = 3'($urandom_range(0, 7));
         ri = m[0]; sys = m[1]; ov = m[2];
         pc = $urandom & 32'hFFFF_FFFC;
         #1;
         checks++; if (exc_sync !== (m != 0) || exc_async !== (m == 0)) begin errors++; $display("FAIL rsync_req m=%0d got s=%b a=%b", m, exc_sync, exc_async); end
         if (m[0])      code = 5'h0a;
         else if (m[1]) code = 5'h08;
         else if (m[2]) code = 5'h0c;
         else           code = 5'h00;
         step(); ri = 0; sys = 0; ov = 0;
         rd(5'd13, 3'd0, r);
         checks++; if (r[6:2] !== code || epc_o !== pc) begin errors++; $display("FAIL rsync_code m=%0d got %h/%h want %h/%h", m, r[6:2], epc_o, code, pc); end
         eret = 1'b1; step(); eret = 1'b0;
      end
   endtask

   task automatic test_count_random();
      logic [31:0] r, v, c;
      int k;
      for (int i = 0; i < 6; i++) begin
         v = (i == 0) ? 32'hFFFF_FFFF : $urandom;
         k = (i == 0) ? 4 : $urandom_range(0, 9);
         wr(5'd9, v);
         repeat (k) step();
         rd(5'd9, 3'd0, r);
         checks++; if (r !== v + 32'(k / DIV)) begin errors++; $display("FAIL count_load got %h want %h", r, v + 32'(k / DIV)); end
      end
      wr(5'd13, 32'h0800_0100);
      rd(5'd9, 3'd0, c);
      repeat (5) step();
      rd(5'd9, 3'd0, r);
      checks++; if (r !== c) begin errors++; $display("FAIL count_dc got %h want %h", r, c); end
      wr(5'd13, 32'h0000_0100);
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      pc = 32'h0000_1234;
      wr(5'd12, 32'h0000_0101);
      step();
      rd(5'd12, 3'd0, r);
      checks++; if (r !== 32'h0000_0103 || epc_o !== 32'h1234) begin errors++; $display("FAIL pre_reset got st=%h epc=%h want 103 1234", r, epc_o); end
      #10 rst = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         logic [4:0] n;
         n = (i == 0) ? 5'd9 : (i == 1) ? 5'd11 : (i == 2) ? 5'd12 : (i == 3) ? 5'd13 : 5'd14;
         rd(n, 3'd0, r);
         checks++; if (r !== 32'd0) begin errors++; $display("FAIL async_rst reg%0d got %h want 0", n, r); end
      end
      checks++; if (epc_o !== 32'd0 || exc_async !== 1'b0 || exc_sync !== 1'b0 || handler !== 32'h180) begin errors++; $display("FAIL async_rst_out got epc=%h a=%b s=%b h=%h", epc_o, exc_async, exc_sync, handler); end
      step();
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_timer();
      test_edge_vector();
      test_level();
      test_sync_priority();
      test_eret();
      test_random_sync();
      test_count_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
